stream_burst_drain: RTL

STREAM_BURST_DRAIN -- requirements
Module: stream_burst_drain

---
 rtl/stream_burst_drain.sv | 123 ++++++++++++
 1 files changed

// File: rtl/stream_burst_drain.sv
// Holds upstream FIFO data until a full burst (or a timed-out partial burst) is available, then drains it.
// Zero-latency pass-through during a burst; backpressure: ready_i passes straight to ready_o, held 0 while idle.
module stream_burst_drain #(
  parameter int  DATA_WIDTH  = 32,
  parameter type T           = logic [DATA_WIDTH-1:0],
  parameter int  BURST_LEN   = 4,
  parameter int  TIMEOUT     = 16,
  parameter int  USAGE_WIDTH = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic [USAGE_WIDTH-1:0] usage_i,
  input  T                       data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output T                       data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   last_o,
  output logic                   timeout_o
);

  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [USAGE_WIDTH-1:0] LEN_FULL = USAGE_WIDTH'(BURST_LEN);
  localparam logic [USAGE_WIDTH-1:0] LEN_ONE  = USAGE_WIDTH'(1);
  localparam logic [WAIT_W-1:0]      WAIT_SAT = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0]      WAIT_HIT = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [WAIT_W-1:0]      WAIT_ONE = WAIT_W'(1);

  if (BURST_LEN < 1 || BURST_LEN > (2 ** USAGE_WIDTH) - 1) begin : g_bad_burst_len
    $error("stream_burst_drain: BURST_LEN must be within 1..2**USAGE_WIDTH-1");
  end

  typedef enum logic {IDLE, BURST} state_t;

  state_t                 state_q, state_d;
  logic [USAGE_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [USAGE_WIDTH-1:0] burst_len_q, burst_len_d;
  logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                   timeout_q, timeout_d;
  logic                   full_hit, tmo_hit, last_beat, hs;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      burst_len_q <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_len_q <= burst_len_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // timeout_o is registered: it marks the first cycle of a timeout-started burst
  assign timeout_o = timeout_q;

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    burst_len_d = burst_len_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = 1'b0;
    valid_o     = 1'b0;
    ready_o     = 1'b0;
    last_o      = 1'b0;
    data_o      = data_i;
    hs          = 1'b0;
    full_hit    = valid_i && (usage_i >= LEN_FULL);
    tmo_hit     = (TIMEOUT != 0) && valid_i && (wait_cnt_q == WAIT_HIT) && !full_hit;
    last_beat   = (beat_cnt_q == burst_len_q - LEN_ONE);

    if (flush_i) begin
      state_d     = IDLE;
      beat_cnt_d  = '0;
      burst_len_d = '0;
      wait_cnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!valid_i)
            wait_cnt_d = '0;
          else if (wait_cnt_q != WAIT_SAT)
            wait_cnt_d = wait_cnt_q + WAIT_ONE;
          if (full_hit) begin
            state_d     = BURST;
            burst_len_d = LEN_FULL;
            beat_cnt_d  = '0;
            wait_cnt_d  = '0;
          end else if (tmo_hit) begin
            state_d     = BURST;
            burst_len_d = (usage_i == '0) ? LEN_ONE : usage_i;
            beat_cnt_d  = '0;
            wait_cnt_d  = '0;
            timeout_d   = 1'b1;
          end
        end
        BURST: begin
          valid_o = valid_i;
          ready_o = ready_i;
          last_o  = last_beat;
          hs      = valid_i && ready_i;
          if (hs) begin
            if (last_beat) begin
              state_d    = IDLE;
              beat_cnt_d = '0;
              wait_cnt_d = '0;
            end else begin
              beat_cnt_d = beat_cnt_q + LEN_ONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
